// File: rtl/rv_pkg.sv
// ============================================================================
// rv_pkg: shared widths and the writeback entry type for the integer core.
// Revision: 1.0
// ============================================================================
`default_nettype none

package rv_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_COUNT  = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;
endpackage

`default_nettype wire

// File: rtl/wb_load_fifo.sv
// ============================================================================
// wb_load_fifo: LQ_DEPTH-entry synchronous FIFO buffering load results.
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_load_fifo
  import rv_pkg::*;
#(
  parameter int LQ_DEPTH = 2
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      i_push,
  input  wb_entry_t i_data,
  input  logic      i_pop,
  output wb_entry_t o_data,
  output logic      o_full,
  output logic      o_empty
);

  localparam int PTR_W = $clog2(LQ_DEPTH);
  localparam int CNT_W = $clog2(LQ_DEPTH + 1);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(LQ_DEPTH);

  wb_entry_t        r_mem [LQ_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == C_FULL);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  // Storage carries no reset; validity is tracked entirely by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/writeback_unit.sv
// ============================================================================
// writeback_unit: merges ALU and load results onto the register file write
// port and tracks pending writes for decode hazard stalls.
// Revision: 1.0
// ============================================================================
`default_nettype none

module writeback_unit
  import rv_pkg::*;
#(
  parameter int LQ_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  alu_valid_i,
  input  logic [REG_ADDR_W-1:0] alu_rd_i,
  input  logic [XLEN-1:0]       alu_data_i,
  input  logic                  ld_valid_i,
  output logic                  ld_ready_o,
  input  logic [REG_ADDR_W-1:0] ld_rd_i,
  input  logic [XLEN-1:0]       ld_data_i,
  input  logic                  issue_valid_i,
  input  logic [REG_ADDR_W-1:0] issue_rd_i,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  output logic                  stall_o,
  output logic                  wr_enable_o,
  output logic [REG_ADDR_W-1:0] wr_addr_o,
  output logic [XLEN-1:0]       wr_data_o
);

  wb_entry_t             w_ld_entry;
  wb_entry_t             w_head;
  wb_entry_t             w_sel;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_sel_valid;
  logic                  w_stall;
  logic [REG_COUNT-1:0]  w_set;
  logic [REG_COUNT-1:0]  w_clr;

  logic                  r_wr_enable;
  logic [REG_ADDR_W-1:0] r_wr_addr;
  logic [XLEN-1:0]       r_wr_data;
  logic [REG_COUNT-1:0]  r_busy;

  assign w_ld_entry = '{rd: ld_rd_i, data: ld_data_i};

  // The buffer pops only when the ALU leaves the write port free.
  wb_load_fifo #(
    .LQ_DEPTH (LQ_DEPTH)
  ) u_load_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (ld_valid_i),
    .i_data  (w_ld_entry),
    .i_pop   (~alu_valid_i),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign ld_ready_o  = ~w_full;
  assign w_sel_valid = alu_valid_i | ~w_empty;
  assign w_sel       = alu_valid_i ? '{rd: alu_rd_i, data: alu_data_i} : w_head;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_enable <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      r_wr_enable <= w_sel_valid && (w_sel.rd != '0);
      if (w_sel_valid) begin
        r_wr_addr <= w_sel.rd;
        r_wr_data <= w_sel.data;
      end
    end
  end

  assign wr_enable_o = r_wr_enable;
  assign wr_addr_o   = r_wr_addr;
  assign wr_data_o   = r_wr_data;

  // Bit 0 is never set, so x0 reads as permanently free.
  assign w_stall = r_busy[rs1_addr_i] | r_busy[rs2_addr_i] | r_busy[issue_rd_i];
  assign stall_o = w_stall;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (r_wr_enable) begin
      w_clr[r_wr_addr] = 1'b1;
    end
    if (issue_valid_i && !w_stall && (issue_rd_i != '0)) begin
      w_set[issue_rd_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
    end
  end

endmodule

`default_nettype wire
